// File: rtl/spi_ram_arbiter.sv
// Two-master round-robin arbiter for a single-port on-chip RAM with 1-cycle read latency.
// Each master sees a pipelined Avalon-MM slave; the RAM pins are driven directly.
module spi_ram_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic              last_grant;
    logic              rd_pend;
    logic              rd_owner;
    logic              rd_issue;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;

    // On a tie the master that was not granted last wins; reset and hold suppress all grants.
    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset && !hold) begin
            if (req0 && req1) begin
                if (last_grant) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // A read that also asserts write is treated as a pure write.
    always_comb begin
        rd_issue = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else begin
            rd_pend <= rd_issue;
            if (rd_issue) begin
                rd_owner <= gnt1;
            end
            if (gnt0 || gnt1) begin
                last_grant <= gnt1;
                addr_q     <= ram_address;
                be_q       <= ram_byteenable;
                wdata_q    <= ram_writedata;
            end
        end
    end

    // Idle RAM pins keep the last granted values so the bus does not toggle.
    always_comb begin
        ram_clken      = 1'b1;
        ram_chipselect = gnt0 | gnt1;
        ram_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
        ram_address    = addr_q;
        ram_byteenable = be_q;
        ram_writedata  = wdata_q;
        if (gnt0) begin
            ram_address    = m0_address;
            ram_byteenable = m0_byteenable;
            ram_writedata  = m0_writedata;
        end else if (gnt1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
        end
    end

    always_comb begin
        m0_waitrequest   = reset | (req0 & ~gnt0);
        m1_waitrequest   = reset | (req1 & ~gnt1);
        m0_readdatavalid = ~reset & rd_pend & ~rd_owner;
        m1_readdatavalid = ~reset & rd_pend & rd_owner;
        m0_readdata      = ram_readdata;
        m1_readdata      = ram_readdata;
    end

endmodule
